// File: rtl/toy_stdin_uart.sv
// UART-to-stdin producer: 8N1 receiver, big-endian byte pairing into 16-bit
// TOY words, and a first-word-fall-through FIFO feeding the core.
module toy_stdin_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rx_i,
  output logic                       in_val_o,
  output logic [15:0]                in_data_o,
  input  logic                       in_rdy_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       half_o,
  output logic                       overrun_o,
  output logic                       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          byte_stb, stop_err;
  logic          rx_m, rx_s, rx_q;

  logic [7:0]    hi;
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          full, push, pop, push_ok;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  // RX state, bit timer, bit index and shift register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // RX next-state: IDLE reacts to a falling edge only, so a line stuck low
  // after a framing error is not re-framed until it goes high and falls again
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    byte_stb  = 1'b0;
    stop_err  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_q && !rx_s) begin
          cnt_n   = CW'(CLKS_PER_BIT/2 - 1);
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            cnt_n     = CW'(CLKS_PER_BIT - 1);
            bit_idx_n = '0;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_n = {rx_s, shreg[7:1]};
          cnt_n   = CW'(CLKS_PER_BIT - 1);
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          state_n = IDLE;
          if (rx_s) byte_stb = 1'b1;
          else      stop_err = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign full    = (level_o == LW'(DEPTH));
  assign pop     = in_val_o && in_rdy_i;
  assign push    = byte_stb && half_o && !flush_i;
  assign push_ok = push && (!full || pop);

  // Word assembler and framing flag; a bad stop bit also drops a held high byte
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi          <= '0;
      half_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else if (flush_i) begin
      hi          <= '0;
      half_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (stop_err) begin
        frame_err_o <= 1'b1;
        half_o      <= 1'b0;
      end
      if (byte_stb) begin
        if (!half_o) begin
          hi     <= shreg;
          half_o <= 1'b1;
        end else begin
          half_o <= 1'b0;
        end
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= {hi, shreg};
  end

  // FIFO pointers, level and overrun; flush wins over push and pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr      <= '0;
      rptr      <= '0;
      level_o   <= '0;
      overrun_o <= 1'b0;
    end else if (flush_i) begin
      wptr      <= '0;
      rptr      <= '0;
      level_o   <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      if (push_ok && !pop)      level_o <= level_o + LW'(1);
      else if (!push_ok && pop) level_o <= level_o - LW'(1);
      if (push && full && !pop) overrun_o <= 1'b1;
    end
  end

  assign in_val_o  = (level_o != '0);
  assign in_data_o = in_val_o ? mem[rptr] : '0;

endmodule
